// File: rtl/config_chain_loader.sv
// Config chain loader: takes host bitstream words and shifts them LSB-first
// into a serial configuration chain of CHAIN_LEN bits.
module config_chain_loader #(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 32,
    localparam int BL_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              Config_Clock,
    input  logic              Config_Reset,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              cfg_bit,
    output logic              cfg_shift_en,
    output logic              busy,
    output logic              done,
    output logic [BL_W-1:0]   bits_left
);

    localparam int CNT_W = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [WORD_W-1:0] shift_reg;
    logic [CNT_W-1:0]  word_cnt;

    // State register; reset drops the block straight back to IDLE.
    always_ff @(posedge Config_Clock or posedge Config_Reset) begin
        if (Config_Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; abort overrides start and any word handshake.
    always_comb begin
        next_state = state;
        if (abort) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) next_state = LOAD;
                end
                LOAD: begin
                    if (word_valid) next_state = SHIFT;
                end
                SHIFT: begin
                    if (bits_left == BL_W'(1)) begin
                        next_state = DONE;
                    end else if (word_cnt == CNT_W'(1)) begin
                        next_state = LOAD;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // Datapath: capture words, shift them out, and track remaining chain bits.
    // The per-word count is clipped to bits_left so surplus upper bits of the
    // final word are never shifted into the chain.
    always_ff @(posedge Config_Clock or posedge Config_Reset) begin
        if (Config_Reset) begin
            bits_left <= '0;
            shift_reg <= '0;
            word_cnt  <= '0;
        end else if (abort) begin
            bits_left <= '0;
            shift_reg <= '0;
            word_cnt  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) bits_left <= BL_W'(CHAIN_LEN);
                end
                LOAD: begin
                    if (word_valid) begin
                        shift_reg <= word_in;
                        word_cnt  <= (int'(bits_left) > WORD_W) ? CNT_W'(WORD_W)
                                                                 : CNT_W'(bits_left);
                    end
                end
                SHIFT: begin
                    shift_reg <= shift_reg >> 1;
                    bits_left <= bits_left - BL_W'(1);
                    word_cnt  <= word_cnt - CNT_W'(1);
                end
                default: begin
                    bits_left <= '0;
                end
            endcase
        end
    end

    // Outputs come purely from state decode and registered data.
    assign word_ready   = (state == LOAD);
    assign cfg_shift_en = (state == SHIFT);
    assign cfg_bit      = (state == SHIFT) && shift_reg[0];
    assign busy         = (state == LOAD) || (state == SHIFT);
    assign done         = (state == DONE);

endmodule
